alu32_seq: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle 32-bit ALU in the execute stage. Registers result and flags. Adds shift-right, arithmetic shift-right, iterative unsigned multiply and divide behind a Start/Busy/Done handshake, so the control unit can stall the pipeline while a long operation runs. Opcode encodings for the existing operations are unchanged, so current control logic drives it directly.

---
 rtl/alu32_seq_pkg.sv | 18 +
 rtl/alu_muldiv_iter.sv | 70 +++++++
 rtl/alu32_seq.sv | 136 +++++++++++++
 tb/tb_alu32_seq.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/alu32_seq_pkg.sv
// Opcodes and FSM state encoding shared by the sequential ALU and its testbench.
package alu_pkg;
  localparam logic [3:0] OP_HOLD  = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_MUL   = 4'b0011;
  localparam logic [3:0] OP_DIV   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_NOT   = 4'b0111;
  localparam logic [3:0] OP_XOR   = 4'b1000;
  localparam logic [3:0] OP_SLL   = 4'b1001;
  localparam logic [3:0] OP_SRL   = 4'b1010;
  localparam logic [3:0] OP_PASSB = 4'b1011;
  localparam logic [3:0] OP_SRA   = 4'b1100;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier / restoring divider; the result is
// offered combinationally on the step where last_o is high.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] result_o,
  output logic             ovf_o
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic             is_div_q;
  logic [WIDTH:0]   hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   acc, rem_sh, trial;

  // hi holds the partial product (mul) or partial remainder (div); lo holds
  // the multiplier bits still to consume or the dividend/quotient shifter.
  always_comb begin
    acc    = hi_q + (lo_q[0] ? {1'b0, b_q} : '0);
    rem_sh = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, b_q};
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (is_div_q) begin
      if (!trial[WIDTH]) begin
        hi_d = trial;
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = rem_sh;
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      {hi_d, lo_d} = {1'b0, acc, lo_q[WIDTH-1:1]};
    end
  end

  assign last_o   = (cnt_q == CW'(1));
  assign result_o = lo_d;
  assign ovf_o    = is_div_q ? (b_q == '0) : (hi_d[WIDTH-1:0] != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
    end else if (load_i) begin
      is_div_q <= is_div_i;
      hi_q     <= '0;
      lo_q     <= a_i;
      b_q      <= b_i;
      cnt_q    <= CW'(WIDTH);
    end else if (step_i) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q - CW'(1);
    end
  end
endmodule

// File: rtl/alu32_seq.sv
// Registered ALU: single-cycle ops finish the next cycle, mul/div take WIDTH+1
// cycles behind Busy; Start while Busy is dropped, never queued.
module alu32_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic [3:0]       ALUsel,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Busy,
  output logic             Done,
  output logic             Equal,
  output logic             Zero,
  output logic             Carry,
  output logic             Overflow
);
  state_t           state_q;
  logic [WIDTH-1:0] res_q;
  logic             busy_q, done_q, eq_q, zero_q, carry_q, ovf_q, eq_pend_q;

  logic [WIDTH:0]   sum, diff;
  logic [SHW-1:0]   shamt;
  logic signed [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry, sc_ovf, is_md, accept;
  logic             md_last, md_ovf;
  logic [WIDTH-1:0] md_res;

  assign shamt  = OperandB[SHW-1:0];
  assign a_s    = OperandA;
  assign sum    = {1'b0, OperandA} + {1'b0, OperandB};
  assign diff   = {1'b0, OperandA} - {1'b0, OperandB};
  assign is_md  = (ALUsel == OP_MUL) || (ALUsel == OP_DIV);
  assign accept = Start && (state_q == ST_IDLE);

  always_comb begin
    sc_res   = sum[WIDTH-1:0];
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    case (ALUsel)
      OP_HOLD:  sc_res = res_q;
      OP_SUB: begin
        sc_res   = diff[WIDTH-1:0];
        sc_carry = ~diff[WIDTH];
        sc_ovf   = (OperandA[WIDTH-1] != OperandB[WIDTH-1]) &&
                   (diff[WIDTH-1] != OperandA[WIDTH-1]);
      end
      OP_AND:   sc_res = OperandA & OperandB;
      OP_OR:    sc_res = OperandA | OperandB;
      OP_NOT:   sc_res = ~OperandA;
      OP_XOR:   sc_res = OperandA ^ OperandB;
      OP_SLL:   sc_res = OperandA << shamt;
      OP_SRL:   sc_res = OperandA >> shamt;
      OP_SRA:   sc_res = a_s >>> shamt;
      OP_PASSB: sc_res = OperandB;
      default: begin
        sc_carry = sum[WIDTH];
        sc_ovf   = (OperandA[WIDTH-1] == OperandB[WIDTH-1]) &&
                   (sum[WIDTH-1] != OperandA[WIDTH-1]);
      end
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .load_i   (accept && is_md),
    .step_i   (state_q == ST_RUN),
    .is_div_i (ALUsel == OP_DIV),
    .a_i      (OperandA),
    .b_i      (OperandB),
    .last_o   (md_last),
    .result_o (md_res),
    .ovf_o    (md_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      res_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      eq_q      <= 1'b0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      eq_pend_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept && is_md) begin
            state_q   <= ST_RUN;
            busy_q    <= 1'b1;
            eq_pend_q <= (OperandA == OperandB);
          end else if (accept) begin
            res_q   <= sc_res;
            zero_q  <= (sc_res == '0);
            eq_q    <= (OperandA == OperandB);
            carry_q <= sc_carry;
            ovf_q   <= sc_ovf;
            done_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          // Final iteration: the unit's combinational result is registered here.
          if (md_last) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            res_q   <= md_res;
            zero_q  <= (md_res == '0);
            eq_q    <= eq_pend_q;
            carry_q <= 1'b0;
            ovf_q   <= md_ovf;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ALUResult = res_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Equal     = eq_q;
  assign Zero      = zero_q;
  assign Carry     = carry_q;
  assign Overflow  = ovf_q;
endmodule

// File: tb/tb_alu32_seq.sv
// Directed vectors for alu32_seq; expected responses are queued at issue time
// and matched by a monitor on every Done pulse.
module tb_alu32_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Start = 1'b0;
  logic [31:0] OperandA = '0, OperandB = '0;
  logic [3:0]  ALUsel = '0;
  logic [31:0] ALUResult;
  logic        Busy, Done, Equal, Zero, Carry, Overflow;

  alu32_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .Start(Start), .OperandA(OperandA), .OperandB(OperandB),
    .ALUsel(ALUsel), .ALUResult(ALUResult), .Busy(Busy), .Done(Done),
    .Equal(Equal), .Zero(Zero), .Carry(Carry), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        z, c, v, e;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  // Monitor: every Done must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (Done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 64'(ALUResult), 64'hDEAD_0000_0000_0000);
        end else begin
          exp_t x;
          x = q.pop_front();
          chk({x.name, "_res"}, 64'(ALUResult), 64'(x.res));
          chk({x.name, "_flags_zcve"}, 64'({Zero, Carry, Overflow, Equal}),
              64'({x.z, x.c, x.v, x.e}));
        end
      end
    end
  end

  task automatic issue(input string nm, input logic [3:0] op, input logic [31:0] a, b,
                       input logic [31:0] res, input logic z, c, v, e, input bit push);
    exp_t x;
    @(posedge clk);
    #1;
    Start = 1'b1; ALUsel = op; OperandA = a; OperandB = b;
    if (push) begin
      x.name = nm; x.res = res; x.z = z; x.c = c; x.v = v; x.e = e;
      q.push_back(x);
    end
    @(posedge clk);
    #1;
    Start = 1'b0;
  endtask

  // Called right after issue(): Busy must cover 32 cycles, then Done with Busy low.
  task automatic md_timing(input string nm);
    bit busy_ok = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (!(Busy && !Done)) busy_ok = 1'b0;
    end
    chk({nm, "_busy_window"}, 64'(busy_ok), 64'd1);
    @(negedge clk);
    chk({nm, "_done_at_33"}, 64'({Done, Busy}), 64'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", 64'({ALUResult, Busy, Done, Equal, Zero, Carry, Overflow}), 64'd0);

    issue("add_wrap",  OP_ADD,   32'hFFFFFFFF, 32'h1,        32'h0,        1, 1, 0, 0, 1);
    issue("sub_ovf",   OP_SUB,   32'h80000000, 32'h1,        32'h7FFFFFFF, 0, 1, 1, 0, 1);
    issue("sub_borrow",OP_SUB,   32'd3,        32'd5,        32'hFFFFFFFE, 0, 0, 0, 0, 1);
    issue("sub_equal", OP_SUB,   32'd5,        32'd5,        32'h0,        1, 1, 0, 1, 1);
    issue("and",       OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 0, 1);
    issue("or",        OP_OR,    32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 0, 0, 0, 0, 1);
    issue("not",       OP_NOT,   32'h0000FFFF, 32'h0000FFFF, 32'hFFFF0000, 0, 0, 0, 1, 1);
    issue("hold",      OP_HOLD,  32'd1,        32'd2,        32'hFFFF0000, 0, 0, 0, 0, 1);
    issue("xor",       OP_XOR,   32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 0, 0, 0, 0, 1);
    issue("sll_trunc", OP_SLL,   32'h1,        32'h21,       32'h2,        0, 0, 0, 0, 1);
    issue("srl",       OP_SRL,   32'h80000000, 32'd31,       32'h1,        0, 0, 0, 0, 1);
    issue("sra",       OP_SRA,   32'h80000000, 32'd4,        32'hF8000000, 0, 0, 0, 0, 1);
    issue("passb",     OP_PASSB, 32'h0,        32'h12345678, 32'h12345678, 0, 0, 0, 0, 1);
    issue("dflt_add",  4'b1101,  32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 0, 1, 0, 1);

    issue("mul_hi",  OP_MUL, 32'h00010000, 32'h00010000, 32'h0,        1, 0, 1, 1, 1);
    md_timing("mul_hi");
    issue("mul_small", OP_MUL, 32'd1234, 32'd5678, 32'd7006652,   0, 0, 0, 0, 1);
    md_timing("mul_small");
    issue("div",     OP_DIV, 32'd100, 32'd7, 32'd14,              0, 0, 0, 0, 1);
    md_timing("div");
    issue("div_zero", OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF,         0, 0, 1, 0, 1);
    md_timing("div_zero");

    // Start while Busy (with new operands) is dropped; Start in the Done cycle is taken.
    issue("div_ign", OP_DIV, 32'd1000, 32'd10, 32'd100,           0, 0, 0, 0, 1);
    repeat (4) @(posedge clk);
    #1 Start = 1'b1; ALUsel = OP_ADD; OperandA = 32'd9; OperandB = 32'd9;
    repeat (4) @(posedge clk);
    #1 Start = 1'b0;
    repeat (24) @(posedge clk);
    #1 Start = 1'b1; ALUsel = OP_ADD; OperandA = 32'd2; OperandB = 32'd3;
    q.push_back('{name: "b2b_add", res: 32'd5, z: 1'b0, c: 1'b0, v: 1'b0, e: 1'b0});
    @(negedge clk);
    chk("b2b_done1", 64'({Done, Busy}), 64'b10);
    @(posedge clk);
    #1 Start = 1'b0;
    @(negedge clk);
    chk("b2b_done2", 64'({Done, Busy}), 64'b10);

    // Reset in cycle t+10 of a multiply aborts it.
    issue("mul_abort", OP_MUL, 32'd3, 32'd4, 32'd12, 0, 0, 0, 0, 0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_outputs", 64'({ALUResult, Busy, Done, Equal, Zero, Carry, Overflow}), 64'd0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done) done_seen++;
    end
    chk("abort_no_done", 64'(done_seen), 64'd0);

    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
